// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control and writeback stage around an 8-bit combinational ALU.
// It accepts one instruction over valid/ready, holds working registers A and B,
// strobes the ALU for a programmable settle time, then writes the result back.

module alu_op_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          DIV0_WRITE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic [7:0] opnd,
    output logic       ISUMn,
    output logic       ISUBn,
    output logic       IMULn,
    output logic       IDIVn,
    output logic       ISHLn,
    output logic       ISHRn,
    output logic       An,
    output logic       Bn,
    output logic [7:0] DinA,
    output logic [7:0] DinB,
    output logic [7:0] Din,
    input  logic [7:0] alu_dout,
    output logic       done,
    output logic [7:0] result,
    output logic       zero,
    output logic       div0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_LDA = 3'b110;
    localparam logic [2:0] OP_LDB = 3'b111;

    // Counter value seen on the last EXEC edge, where the writeback happens.
    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic [2:0] op;
    logic       dst;
    logic [3:0] cnt;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    // Active-low strobes, ordered {SUM, SUB, MUL, DIV, SHL, SHR}.
    logic [5:0] strobe_n;

    logic       is_load;
    logic       div_zero;
    logic       write_b;
    logic       write_en;
    logic [7:0] write_val;

    // Reserved instruction bits carry no meaning; they are folded into a sink.
    logic unused_reserved;
    assign unused_reserved = ^instr[7:5];

    // Maps an opcode onto the single strobe it drives low; loads drive none.
    function automatic logic [5:0] decode_strobe(input logic [2:0] code);
        logic [5:0] s;
        s = 6'b111111;
        case (code)
            OP_SUM:  s[5] = 1'b0;
            OP_SUB:  s[4] = 1'b0;
            OP_MUL:  s[3] = 1'b0;
            OP_DIV:  s[2] = 1'b0;
            OP_SHL:  s[1] = 1'b0;
            OP_SHR:  s[0] = 1'b0;
            default: s = 6'b111111;
        endcase
        return s;
    endfunction

    assign {ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn} = strobe_n;
    assign Bn          = ~An;
    assign DinA        = a_reg;
    assign DinB        = b_reg;
    assign instr_ready = (state == IDLE) && !rst;

    // Writeback decisions for the instruction currently in EXEC.
    always_comb begin
        is_load   = (op == OP_LDA) || (op == OP_LDB);
        div_zero  = (op == OP_DIV) && (Din == 8'h00);
        write_b   = is_load ? op[0] : dst;
        write_val = is_load ? Din : alu_dout;
        write_en  = !(div_zero && !DIV0_WRITE);
    end

    // Sequencer FSM: accept in IDLE, strobe the ALU in EXEC, pulse done in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= OP_SUM;
            dst      <= 1'b0;
            cnt      <= 4'd0;
            strobe_n <= 6'b111111;
            An       <= 1'b0;
            Din      <= 8'h00;
            a_reg    <= 8'h00;
            b_reg    <= 8'h00;
            result   <= 8'h00;
            zero     <= 1'b0;
            div0     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (instr_valid) begin
                        op       <= instr[4:2];
                        An       <= instr[1];
                        dst      <= instr[0];
                        Din      <= opnd;
                        cnt      <= 4'd0;
                        strobe_n <= decode_strobe(instr[4:2]);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == LAST_CNT) begin
                        strobe_n <= 6'b111111;
                        result   <= write_val;
                        zero     <= (write_val == 8'h00);
                        div0     <= div_zero;
                        done     <= 1'b1;
                        state    <= DONE;
                        if (write_en) begin
                            if (write_b) begin
                                b_reg <= write_val;
                            end else begin
                                a_reg <= write_val;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    strobe_n <= 6'b111111;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (settle 1 cycle with suppressed
// divide-by-zero writes, settle 3 cycles with divide-by-zero writes), each with a
// behavioural ALU. Expected completions go into a queue; a monitor checks them.

module tb_alu_op_sequencer;

    typedef struct packed {
        logic [7:0] result;
        logic       zero;
        logic       div0;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    logic       valid    [2];
    logic [7:0] instr    [2];
    logic [7:0] opnd     [2];
    logic       ready    [2];
    logic       ISUMn    [2];
    logic       ISUBn    [2];
    logic       IMULn    [2];
    logic       IDIVn    [2];
    logic       ISHLn    [2];
    logic       ISHRn    [2];
    logic       An       [2];
    logic       Bn       [2];
    logic [7:0] DinA     [2];
    logic [7:0] DinB     [2];
    logic [7:0] Din      [2];
    logic [7:0] alu_dout [2];
    logic       done     [2];
    logic [7:0] result   [2];
    logic       zero     [2];
    logic       div0     [2];
    logic [5:0] strb     [2];

    exp_t q0[$];
    exp_t q1[$];

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer #(.EXEC_CYCLES(1), .DIV0_WRITE(1'b0)) u0 (
        .clk(clk), .rst(rst), .instr_valid(valid[0]), .instr_ready(ready[0]),
        .instr(instr[0]), .opnd(opnd[0]),
        .ISUMn(ISUMn[0]), .ISUBn(ISUBn[0]), .IMULn(IMULn[0]), .IDIVn(IDIVn[0]),
        .ISHLn(ISHLn[0]), .ISHRn(ISHRn[0]), .An(An[0]), .Bn(Bn[0]),
        .DinA(DinA[0]), .DinB(DinB[0]), .Din(Din[0]), .alu_dout(alu_dout[0]),
        .done(done[0]), .result(result[0]), .zero(zero[0]), .div0(div0[0])
    );

    alu_op_sequencer #(.EXEC_CYCLES(3), .DIV0_WRITE(1'b1)) u1 (
        .clk(clk), .rst(rst), .instr_valid(valid[1]), .instr_ready(ready[1]),
        .instr(instr[1]), .opnd(opnd[1]),
        .ISUMn(ISUMn[1]), .ISUBn(ISUBn[1]), .IMULn(IMULn[1]), .IDIVn(IDIVn[1]),
        .ISHLn(ISHLn[1]), .ISHRn(ISHRn[1]), .An(An[1]), .Bn(Bn[1]),
        .DinA(DinA[1]), .DinB(DinB[1]), .Din(Din[1]), .alu_dout(alu_dout[1]),
        .done(done[1]), .result(result[1]), .zero(zero[1]), .div0(div0[1])
    );

    // Behavioural ALU: division by zero yields 0xFF, shifts use the low 3 bits.
    function automatic logic [7:0] alu_model(input logic [5:0] s, input logic [7:0] a,
                                             input logic [7:0] b);
        case (s)
            6'b011111: return a + b;
            6'b101111: return a - b;
            6'b110111: return a * b;
            6'b111011: return (b == 8'h00) ? 8'hFF : a / b;
            6'b111101: return a << b[2:0];
            6'b111110: return a >> b[2:0];
            default:   return 8'h00;
        endcase
    endfunction

    function automatic exp_t mk(input logic [7:0] r, input logic z, input logic d,
                                input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.result = r;
        e.zero   = z;
        e.div0   = d;
        e.a      = a;
        e.b      = b;
        return e;
    endfunction

    // ALU environment for both instances, driven from the sequencer outputs.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            strb[i]     = {ISUMn[i], ISUBn[i], IMULn[i], IDIVn[i], ISHLn[i], ISHRn[i]};
            alu_dout[i] = alu_model(strb[i], An[i] ? DinB[i] : DinA[i], Din[i]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_vec++;
        n_bad++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // Scoreboard monitor: every done pulse pops and compares one expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                exp_t e;
                bit   got;
                got = 1'b0;
                if (i == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    got = 1'b1;
                end else if (i == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    got = 1'b1;
                end
                if (!got) begin
                    n_vec++;
                    n_bad++;
                    $display("[TB] FAIL u%0d unexpected done: got 1, expected 0", i);
                end else begin
                    checkOutput($sformatf("u%0d result", i), 32'(result[i]), 32'(e.result));
                    checkOutput($sformatf("u%0d zero", i), 32'(zero[i]), 32'(e.zero));
                    checkOutput($sformatf("u%0d div0", i), 32'(div0[i]), 32'(e.div0));
                    checkOutput($sformatf("u%0d A", i), 32'(DinA[i]), 32'(e.a));
                    checkOutput($sformatf("u%0d B", i), 32'(DinB[i]), 32'(e.b));
                end
            end
        end
    end

    task automatic pushExp(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Waits for ready, presents one instruction for the accept edge, then scrambles inputs.
    task automatic applyStimulus(input int i, input logic [7:0] ins, input logic [7:0] val,
                                 input exp_t e, input bit expect_done);
        int waited;
        waited = 0;
        @(negedge clk);
        while (ready[i] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (ready[i] !== 1'b1) begin
            failNow($sformatf("u%0d ready wait", i));
            return;
        end
        valid[i] = 1'b1;
        instr[i] = ins;
        opnd[i]  = val;
        if (expect_done) pushExp(i, e);
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
        instr[i] = 8'hA5;
        opnd[i]  = 8'h5A;
    endtask

    task automatic waitDrain(input int i);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(ready[i] === 1'b1 && (i == 0 ? q0.size() : q1.size()) == 0) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (ready[i] !== 1'b1 || (i == 0 ? q0.size() : q1.size()) != 0)
            failNow($sformatf("u%0d drain", i));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        int t0, t1, sub_low, shl_low, multi;
        bit got1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            instr[i] = 8'h00;
            opnd[i]  = 8'h00;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("u0 ready in reset", 32'(ready[0]), 32'd0);
        checkOutput("u1 ready in reset", 32'(ready[1]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset strobes", 32'(strb[0]), 32'h3F);
        checkOutput("reset An", 32'(An[0]), 32'd0);
        checkOutput("reset Bn", 32'(Bn[0]), 32'd1);
        checkOutput("reset DinA", 32'(DinA[0]), 32'd0);
        checkOutput("reset DinB", 32'(DinB[0]), 32'd0);
        checkOutput("reset Din", 32'(Din[0]), 32'd0);
        checkOutput("reset done", 32'(done[0]), 32'd0);
        checkOutput("reset ready", 32'(ready[0]), 32'd1);

        // LDA 0x12 then SUM A+0x05 -> A.
        applyStimulus(0, 8'h18, 8'h12, mk(8'h12, 1'b0, 1'b0, 8'h12, 8'h00), 1'b1);
        waitDrain(0);
        applyStimulus(0, 8'h00, 8'h05, mk(8'h17, 1'b0, 1'b0, 8'h17, 8'h00), 1'b1);
        @(negedge clk);
        checkOutput("sum strobe in exec", 32'(strb[0]), 32'h1F);
        @(negedge clk);
        checkOutput("sum strobe after exec", 32'(strb[0]), 32'h3F);
        checkOutput("sum done timing", 32'(done[0]), 32'd1);
        waitDrain(0);

        // LDB 0x40 then DIV B/0 -> B, write suppressed.
        applyStimulus(0, 8'h1C, 8'h40, mk(8'h40, 1'b0, 1'b0, 8'h17, 8'h40), 1'b1);
        waitDrain(0);
        applyStimulus(0, 8'h0F, 8'h00, mk(8'hFF, 1'b0, 1'b1, 8'h17, 8'h40), 1'b1);
        @(negedge clk);
        checkOutput("div strobe in exec", 32'(strb[0]), 32'h3B);
        waitDrain(0);

        // LDA 0x05 then SUB A-5 -> B with reserved bits set.
        applyStimulus(0, 8'h18, 8'h05, mk(8'h05, 1'b0, 1'b0, 8'h05, 8'h40), 1'b1);
        waitDrain(0);
        applyStimulus(0, 8'hE5, 8'h05, mk(8'h00, 1'b1, 1'b0, 8'h05, 8'h00), 1'b1);
        @(negedge clk);
        checkOutput("sub An in exec", 32'(An[0]), 32'd0);
        checkOutput("sub strobe in exec", 32'(strb[0]), 32'h2F);
        waitDrain(0);

        // MUL A*3 -> A.
        applyStimulus(0, 8'h08, 8'h03, mk(8'h0F, 1'b0, 1'b0, 8'h0F, 8'h00), 1'b1);
        waitDrain(0);

        // Second instance: LDA 7, then back-to-back SUB and SHL with valid held.
        applyStimulus(1, 8'h18, 8'h07, mk(8'h07, 1'b0, 1'b0, 8'h07, 8'h00), 1'b1);
        waitDrain(1);
        valid[1] = 1'b1;
        instr[1] = 8'h04;
        opnd[1]  = 8'h02;
        pushExp(1, mk(8'h05, 1'b0, 1'b0, 8'h05, 8'h00));
        t0 = cyc;
        t1 = t0;
        @(posedge clk);
        #1;
        instr[1] = 8'h11;
        opnd[1]  = 8'h01;
        pushExp(1, mk(8'h0A, 1'b0, 1'b0, 8'h05, 8'h0A));
        got1 = 1'b0;
        sub_low = 0;
        shl_low = 0;
        multi = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (strb[1][4] === 1'b0) sub_low++;
            if (strb[1][1] === 1'b0) shl_low++;
            if ($countones(~strb[1]) > 1) multi++;
            if (ready[1] === 1'b1 && !got1) begin
                t1 = cyc;
                got1 = 1'b1;
                @(posedge clk);
                #1;
                valid[1] = 1'b0;
                instr[1] = 8'hA5;
            end
        end
        valid[1] = 1'b0;
        checkOutput("second accept spacing", 32'(t1 - t0), 32'd5);
        checkOutput("sub strobe cycles", 32'(sub_low), 32'd3);
        checkOutput("shl strobe cycles", 32'(shl_low), 32'd3);
        checkOutput("overlapping strobes", 32'(multi), 32'd0);
        waitDrain(1);

        // MUL interrupted by reset during its second EXEC cycle.
        applyStimulus(1, 8'h08, 8'h03, mk(8'h00, 1'b0, 1'b0, 8'h00, 8'h00), 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("mul strobe before reset", 32'(strb[1]), 32'h37);
        @(negedge clk);
        checkOutput("reset strobes mid exec", 32'(strb[1]), 32'h3F);
        checkOutput("reset A mid exec", 32'(DinA[1]), 32'd0);
        checkOutput("reset B mid exec", 32'(DinB[1]), 32'd0);
        checkOutput("reset ready mid exec", 32'(ready[1]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after reset", 32'(ready[1]), 32'd1);
        repeat (4) @(negedge clk);

        // Divide-by-zero with write enabled, then normal divide and shift.
        applyStimulus(1, 8'h1C, 8'h40, mk(8'h40, 1'b0, 1'b0, 8'h00, 8'h40), 1'b1);
        waitDrain(1);
        applyStimulus(1, 8'h0F, 8'h00, mk(8'hFF, 1'b0, 1'b1, 8'h00, 8'hFF), 1'b1);
        waitDrain(1);
        applyStimulus(1, 8'h0E, 8'h08, mk(8'h1F, 1'b0, 1'b0, 8'h1F, 8'hFF), 1'b1);
        waitDrain(1);
        applyStimulus(1, 8'h14, 8'h02, mk(8'h07, 1'b0, 1'b0, 8'h07, 8'hFF), 1'b1);
        waitDrain(1);
        waitDrain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
